// File: rtl/alu_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_rr_arbiter
// Brief    : Round-robin arbiter sharing one external combinational ALU among
//            els_p requesters, with a single-entry valid/yumi result register.
// Revision : 1.0 - initial release
// ============================================================================
module alu_rr_arbiter #(
    parameter int width_p    = 4,
    parameter int els_p      = 2,
    parameter int id_width_p = $clog2(els_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic [els_p-1:0]           v_i,
    input  logic [2*els_p-1:0]         sel_i,
    input  logic [width_p*els_p-1:0]   a_i,
    input  logic [width_p*els_p-1:0]   b_i,
    output logic [els_p-1:0]           ready_o,
    output logic [1:0]                 alu_sel_o,
    output logic [width_p-1:0]         alu_a_o,
    output logic [width_p-1:0]         alu_b_o,
    input  logic [width_p-1:0]         alu_res_i,
    output logic                       v_o,
    output logic [width_p-1:0]         res_o,
    output logic [id_width_p-1:0]      id_o,
    input  logic                       yumi_i
);

    logic                  r_v;
    logic [width_p-1:0]    r_res;
    logic [id_width_p-1:0] r_id;
    logic [id_width_p-1:0] r_last;

    logic                  w_can_accept;
    logic                  w_any;
    logic                  w_fire;
    logic [id_width_p-1:0] w_pick;

    assign w_can_accept = !r_v || yumi_i;

    // Walk the search order backwards so the earliest valid candidate
    // (closest after r_last) is the last assignment and therefore wins.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        for (int i = els_p; i >= 1; i--) begin
            if (v_i[(int'(r_last) + i) % els_p]) begin
                w_any  = 1'b1;
                w_pick = id_width_p'((int'(r_last) + i) % els_p);
            end
        end
    end

    // Grants are suppressed while reset is held so ready_o is quiet immediately.
    assign w_fire = reset_n_i && w_can_accept && w_any;

    generate
        for (genvar k = 0; k < els_p; k++) begin : g_ready
            assign ready_o[k] = w_fire && (w_pick == id_width_p'(k));
        end
    endgenerate

    assign alu_sel_o = w_fire ? sel_i[2*int'(w_pick) +: 2]           : '0;
    assign alu_a_o   = w_fire ? a_i[width_p*int'(w_pick) +: width_p] : '0;
    assign alu_b_o   = w_fire ? b_i[width_p*int'(w_pick) +: width_p] : '0;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_v    <= 1'b0;
            r_res  <= '0;
            r_id   <= '0;
            r_last <= id_width_p'(els_p - 1);
        end else if (w_fire) begin
            r_v    <= 1'b1;
            r_res  <= alu_res_i;
            r_id   <= w_pick;
            r_last <= w_pick;
        end else if (yumi_i) begin
            r_v    <= 1'b0;
        end
    end

    assign v_o   = r_v;
    assign res_o = r_res;
    assign id_o  = r_id;

endmodule
`default_nettype wire

// File: tb/tb_alu_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_rr_arbiter
// Brief    : Directed self-checking bench for alu_rr_arbiter (els_p=2 and 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_rr_arbiter;

    logic clk;
    logic rst_n;

    // two-requester instance
    logic [1:0] v2, ready2, sel2_o;
    logic [3:0] sel2;
    logic [7:0] a2, b2;
    logic [3:0] alu_a2, alu_b2, alu_res2, res2;
    logic       vo2, id2, yumi2;

    // three-requester instance
    logic [2:0]  v3, ready3;
    logic [5:0]  sel3;
    logic [11:0] a3, b3;
    logic [1:0]  sel3_o, id3;
    logic [3:0]  alu_a3, alu_b3, alu_res3, res3;
    logic        vo3, yumi3;

    int n_vec;
    int n_err;

    // Bench ALU: 00 add, 01 sub, 10 and, 11 xor
    function automatic logic [3:0] alu_f(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_res2 = alu_f(sel2_o, alu_a2, alu_b2);
    assign alu_res3 = alu_f(sel3_o, alu_a3, alu_b3);

    alu_rr_arbiter #(.width_p(4), .els_p(2)) u_dut2 (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v2), .sel_i(sel2), .a_i(a2), .b_i(b2),
        .ready_o(ready2), .alu_sel_o(sel2_o), .alu_a_o(alu_a2), .alu_b_o(alu_b2),
        .alu_res_i(alu_res2), .v_o(vo2), .res_o(res2), .id_o(id2), .yumi_i(yumi2)
    );

    alu_rr_arbiter #(.width_p(4), .els_p(3)) u_dut3 (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v3), .sel_i(sel3), .a_i(a3), .b_i(b3),
        .ready_o(ready3), .alu_sel_o(sel3_o), .alu_a_o(alu_a3), .alu_b_o(alu_b3),
        .alu_res_i(alu_res3), .v_o(vo3), .res_o(res3), .id_o(id3), .yumi_i(yumi3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        v2 = '0; sel2 = '0; a2 = '0; b2 = '0; yumi2 = 1'b0;
        v3 = '0; sel3 = '0; a3 = '0; b3 = '0; yumi3 = 1'b0;
        #2;
        v2 = 2'b11;
        #1;
        check("rst_ready",  32'(ready2), 0);
        check("rst_v",      32'(vo2),    0);
        check("rst_res",    32'(res2),   0);
        check("rst_id",     32'(id2),    0);
        check("rst_alu_a",  32'(alu_a2), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // fairness: slice0 add 2+5=7, slice1 sub 9-4=5
        sel2 = 4'b01_00; a2 = 8'h92; b2 = 8'h45; yumi2 = 1'b1; v2 = 2'b11;
        #1;
        check("fair_rdy0", 32'(ready2), 32'h1);
        step();
        check("fair_v0",   32'(vo2),    1);
        check("fair_id0",  32'(id2),    0);
        check("fair_res0", 32'(res2),   7);
        check("fair_rdy1", 32'(ready2), 32'h2);
        step();
        check("fair_id1",  32'(id2),    1);
        check("fair_res1", 32'(res2),   5);
        check("fair_rdy2", 32'(ready2), 32'h1);
        step();
        check("fair_id2",  32'(id2),    0);
        check("fair_rdy3", 32'(ready2), 32'h2);
        step();
        check("fair_id3",  32'(id2),    1);

        // single request on requester 0: add 1+3
        v2 = 2'b01; a2 = 8'h91; b2 = 8'h43;
        #1;
        check("one_ready", 32'(ready2), 32'h1);
        check("one_alu_a", 32'(alu_a2), 1);
        check("one_alu_b", 32'(alu_b2), 3);
        check("one_sel",   32'(sel2_o), 0);
        step();
        check("one_v",     32'(vo2),    1);
        check("one_res",   32'(res2),   4);
        check("one_id",    32'(id2),    0);

        // backpressure: result must hold, no grants
        yumi2 = 1'b0; v2 = 2'b11;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_ready", 32'(ready2), 0);
            check("bp_alu_a", 32'(alu_a2), 0);
            check("bp_res",   32'(res2),   4);
            check("bp_id",    32'(id2),    0);
            check("bp_v",     32'(vo2),    1);
            step();
        end
        yumi2 = 1'b1;
        #1;
        check("bp_release", 32'(ready2), 32'h2);
        step();
        check("bp_new_v",   32'(vo2),    1);
        check("bp_new_res", 32'(res2),   5);
        check("bp_new_id",  32'(id2),    1);

        // drain
        v2 = 2'b00;
        step();
        check("drain_v",   32'(vo2),  0);
        check("drain_res", 32'(res2), 5);
        check("drain_id",  32'(id2),  1);

        // result wrap: F+1 -> 0
        v2 = 2'b01; a2 = 8'h9F; b2 = 8'h41; yumi2 = 1'b0;
        #1;
        check("wrap_ready", 32'(ready2), 32'h1);
        step();
        v2 = 2'b00;
        check("wrap_v",   32'(vo2),  1);
        check("wrap_res", 32'(res2), 0);
        step();
        check("wrap_hold", 32'(vo2), 1);
        yumi2 = 1'b1;
        step();
        check("wrap_deq", 32'(vo2), 0);
        // spurious yumi with nothing held
        step();
        check("spur_v",     32'(vo2),    0);
        check("spur_res",   32'(res2),   0);
        check("spur_id",    32'(id2),    0);
        check("spur_ready", 32'(ready2), 0);
        // idle cycles leave priority with requester 1 (last grant was 0)
        v2 = 2'b11;
        #1;
        check("idle_keep", 32'(ready2), 32'h2);
        step();
        check("idle_id", 32'(id2), 1);

        // asynchronous reset mid-cycle
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_v",     32'(vo2),    0);
        check("arst_res",   32'(res2),   0);
        check("arst_ready", 32'(ready2), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("arst_first", 32'(ready2), 32'h1);
        v2 = 2'b00;
        step();

        // three requesters: slice2 add 3+4=7, slice0 add 5+6=11
        yumi3 = 1'b1;
        sel3 = 6'b00_00_00; a3 = 12'h305; b3 = 12'h406;
        v3 = 3'b100;
        #1;
        check("w3_first", 32'(ready3), 32'h4);
        step();
        check("w3_id2",  32'(id3),  2);
        check("w3_res2", 32'(res3), 7);
        v3 = 3'b101;
        #1;
        check("w3_wrap", 32'(ready3), 32'h1);
        step();
        check("w3_id0",  32'(id3),  0);
        check("w3_res0", 32'(res3), 11);
        #1;
        check("w3_next", 32'(ready3), 32'h4);
        step();
        check("w3_id2b", 32'(id3), 2);
        v3 = 3'b000;
        step();
        check("w3_idle_v", 32'(vo3), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one combinational ALU (sel_i[1:0], a_i, b_i -> res_o) among els_p requesters.
- Picks one requester per cycle using round-robin priority and drives its operands onto the ALU.
- Captures the ALU result in a single-entry output register with valid/yumi handshake.
- Sits between requester clients and the ALU instance; the ALU stays outside this block.

Parameters:
- width_p, 4, operand/result width; must match the ALU's width_p.
- els_p, 2, number of requesters; legal range 2..16.
- id_width_p, $clog2(els_p), width of the requester id tag.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- v_i  in  els_p  per-requester request valid.
- sel_i  in  2*els_p  per-requester ALU op; requester k uses bits [2k+1:2k].
- a_i  in  width_p*els_p  per-requester operand A; slice k.
- b_i  in  width_p*els_p  per-requester operand B; slice k.
- ready_o  out  els_p  one-hot grant; request k accepted this cycle.
- alu_sel_o  out  2  op to ALU.
- alu_a_o  out  width_p  operand A to ALU.
- alu_b_o  out  width_p  operand B to ALU.
- alu_res_i  in  width_p  ALU result, combinational from alu_* outputs.
- v_o  out  1  result valid.
- res_o  out  width_p  registered result.
- id_o  out  id_width_p  index of the requester that owns res_o.
- yumi_i  in  1  consumer takes res_o this cycle.

Behaviour:
- Reset (reset_n_i=0, async, takes effect immediately):
  - v_o=0, res_o=0, id_o=0.
  - Round-robin pointer last_r=els_p-1, so requester 0 has top priority first.
  - ready_o=0.
  - Any pending result is dropped.
- can_accept = !v_o | yumi_i. Same-cycle dequeue and enqueue is allowed.
- Grant is combinational:
  - If can_accept and |v_i, grant the first valid requester searching last_r+1, last_r+2, ... modulo els_p.
  - ready_o is the one-hot of that requester; otherwise ready_o=0.
  - At most one ready_o bit is ever set.
- ALU drive:
  - alu_sel_o/alu_a_o/alu_b_o = granted requester's slices.
  - With no grant, all three are 0 so the ALU inputs are deterministic.
- On a rising edge with a grant to k: res_r<=alu_res_i, id_r<=k, v_r<=1, last_r<=k.
- On a rising edge with yumi_i and no grant: v_r<=0; res_r and id_r hold.
- No grant and no yumi_i: all state holds.
- Latency: 1 cycle from ready_o[k]=1 to v_o=1 with id_o=k. Throughput is 1 result/cycle while yumi_i stays high.
- res_o/id_o are stable while v_o=1 and yumi_i=0.
- yumi_i when v_o=0 is a protocol error. The block ignores it (can_accept is already 1).
- A requester drops v_i or changes operands only in cycles where its ready_o=0. The block does not latch unaccepted requests.
- Round-robin wrap: after a grant to els_p-1, the search restarts at 0.
- last_r updates only on a grant. Idle cycles do not rotate priority.
- Arithmetic: the block does no arithmetic on data. res_o equals alu_res_i bit-for-bit, and width wrap belongs to the ALU.
- Starvation bound: a continuously valid requester is granted within els_p grants.

Test Plan:
- Reset: run traffic, drop reset_n_i mid-cycle -> v_o=0, res_o=0, ready_o=0 before the next edge. After release, requester 0 is granted first when all are valid.
- Single request, els_p=2, bench ALU op 00=add: v_i=01, sel=00, a=4'd1, b=4'd3 -> same cycle ready_o=01, alu_a_o=1, alu_b_o=3, alu_sel_o=00. Next cycle v_o=1, res_o=4'd4, id_o=0.
- Fairness: v_i=11 held, yumi_i=1 every cycle -> ready_o sequence 01,10,01,10. id_o lags by one cycle: 0,1,0,1.
- Backpressure: v_o=1, yumi_i=0 for 5 cycles with v_i=11 -> ready_o=00 and res_o/id_o unchanged. Cycle with yumi_i=1 -> ready_o nonzero and a new result next cycle.
- Wrap, els_p=3: grant to 2, then v_i=101 -> next grant ready_o=001. Then v_i=101 again -> grant 100.
- Result wrap, bench add: a=4'hF, b=4'h1 -> res_o=4'h0, v_o=1. A spurious yumi_i with v_o=0 does not change state.
